cache_controller: RTL and testbench
===================================

# cache_controller

Write-back, write-allocate controller for the 2-way set-associative cache memory array. It accepts one full-line CPU request at a time and performs the tag lookup. On a hit it completes in place; on a miss it sequences the dirty-victim writeback, the memory refill and the line install. It sits between the CPU port and the cache memory array, and owns all request, write-enable, tag and valid/dirty drive into that array plus the per-set LRU state.

## Interface
- ADDRESS_WIDTH, 32, byte address width
- SETS, 1024, sets per way (power of two)
- WAYS, 2, associativity; only 2 is supported
- CACHE_LINE_SIZE, 32, line width in bits; CPU and memory transfers are one full line
- TAG_WIDTH, ADDRESS_WIDTH-(clog2(SETS)+clog2(CACHE_LINE_SIZE/8)), tag bits

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high; clock clk
- cpu_req  in  1  request valid
- cpu_wen  in  1  1 = write, 0 = read
- cpu_addr  in  ADDRESS_WIDTH  request address
- cpu_wdata  in  CACHE_LINE_SIZE  write line
- cpu_ready  out  1  controller idle; request accepted when cpu_req & cpu_ready
- cpu_resp_valid  out  1  one-cycle completion pulse
- cpu_rdata  out  CACHE_LINE_SIZE  read line, valid with cpu_resp_valid on reads
- mem_req, mem_wen  out  1 each  memory request and direction
- mem_addr  out  ADDRESS_WIDTH  line address (offset bits zero)
- mem_wdata  out  CACHE_LINE_SIZE  writeback data
- mem_rdata  in  CACHE_LINE_SIZE  refill data, valid with mem_ack
- mem_ack  in  1  completes the current memory request
- cm_req  out  1  array access
- cm_address  out  ADDRESS_WIDTH  array address
- cm_data_in  out  CACHE_LINE_SIZE  array write data
- cm_tag_in  out  TAG_WIDTH  array tag write
- cm_valid_dirty_in  out  2 per way  bit0 valid, bit1 dirty
- cm_wen_data, cm_wen_tag  out  WAYS  per-way write enables
- cm_data_out  in  CACHE_LINE_SIZE per way  array read data, 1-cycle latency
- cm_tag_out  in  TAG_WIDTH per way  array read tag
- cm_valid_dirty_out  in  2 per way  array read valid/dirty

## Operation
- **Address fields:** offset = low clog2(CACHE_LINE_SIZE/8) bits, then set, then tag.
- **LRU state:** a SETS-entry register of 1 bit, holding the way to evict next. Reset clears it to 0. Each hit or install to way w sets it to ~w.
- **IDLE**
  - cpu_ready = 1; cm_req = cpu_req, cm_address = cpu_addr, no writes.
  - On accept, latch address, wen and wdata, then go to LOOKUP.
- **LOOKUP**
  - Array outputs are valid this cycle. hit_w = valid bit & tag match; way 0 wins if both ways hit.
  - Read hit: cpu_resp_valid = 1, cpu_rdata = data of the hit way, update LRU, go to IDLE.
  - Write hit: in the same cycle drive cm_req = 1, cm_wen_data[w] = cm_wen_tag[w] = 1, cm_data_in = wdata, cm_tag_in = tag, valid_dirty = 2'b11. Pulse cpu_resp_valid, update LRU, go to IDLE.
  - Miss, victim choice: the lowest-index invalid way, else the LRU way.
  - Miss, next state:
    - Victim valid and dirty: latch victim tag and data, go to WRITEBACK.
    - Otherwise, a read goes to REFILL and a write goes to INSTALL. A full-line write needs no refill.
- **WRITEBACK**
  - Drive mem_req = 1, mem_wen = 1, mem_addr = {victim tag, set, 0}, mem_wdata = victim data.
  - On mem_ack: a read goes to REFILL, a write goes to INSTALL.
- **REFILL**
  - Drive mem_req = 1, mem_wen = 0, mem_addr = {tag, set, 0}.
  - On mem_ack, latch mem_rdata and go to INSTALL.
- **INSTALL**
  - Write the victim way: data = wdata (write) or refill data (read), tag = the request tag, valid_dirty = 2'b11 (write) or 2'b01 (read).
  - Pulse cpu_resp_valid; for a read, cpu_rdata = refill data. Update LRU, go to IDLE.
- **Address hold:** cm_address = latched address in every state except IDLE.
- **Array contents:** the array contents are not cleared by rst. The controller does no flush.

## Timing
- **During rst:** all outputs are 0, state goes to IDLE and LRU is cleared. cpu_ready = 1 on the first cycle after rst deasserts.
- **Reset mid-operation:** a reset in any state abandons the request. mem_req drops on the next cycle, and no array write or response is issued.
- **Memory handshake:** mem_req, mem_addr, mem_wen and mem_wdata are held stable until mem_ack is sampled high. mem_ack in the same cycle as the first mem_req is legal. mem_ack outside mem_req is ignored.
- **Latency**, counted from the accept edge (cycle 0):
  - Hit: response in cycle 1.
  - Clean read miss: response in cycle 1 + A + 1, where A is the number of REFILL cycles up to and including mem_ack.
  - Clean write miss: response in cycle 2.
  - Dirty miss: add the WRITEBACK cycles.
- **Busy behaviour:** cpu_req is ignored while cpu_ready = 0. Exactly one response is issued per accepted request.

## Test plan
- **Read miss then hit:** reset, read 0x00001004; ack 3 cycles later with 0xDEADBEEF. Required: mem_addr 0x00001004, mem_wen 0, cpu_rdata 0xDEADBEEF. A re-read gives a response at cycle 1 with no mem_req.
- **Write hit:** then write 0x00001004 = 0x12345678. Required: response at cycle 1 with no mem traffic. A following read returns 0x12345678.
- **LRU eviction:** reset, then read 0x1004 (way 0), read 0x2004 (way 1), read 0x1004 (hit), read 0x3004. Required: way 1 is evicted with no writeback. A following read of 0x2004 misses; a read of 0x1004 hits.
- **Dirty eviction:** reset, write 0x1004 = 0xA, write 0x2004 = 0xB. Required: no mem_req for either write. Then read 0x3004. Required: a writeback of 0xA to 0x1004 (mem_wen 1), then a refill read of 0x3004, then the response.
- **Reset during REFILL:** assert rst while mem_req = 1 in REFILL. Required: mem_req = 0 the next cycle and cpu_ready = 1 after release. A re-read of the same address misses again.
- **Request while busy:** hold cpu_req high with a different address during a miss. Required: it is accepted only on the first IDLE cycle, and exactly 2 responses are issued.

Source files
------------

// File: rtl/cache_controller.sv
// cache_controller: write-back, write-allocate controller for a 2-way set-associative line array.
// Latency: a hit responds 1 cycle after accept. A miss adds the writeback and refill memory cycles plus one install cycle.
// Backpressure: cpu_ready stays low while a request is in flight. Memory requests hold stable until mem_ack.
//
// Ports:
//   clk, rst              clock and synchronous active-high reset (all outputs forced low while rst is high)
//   cpu_*                 one full-line request at a time; cpu_resp_valid pulses once per accepted request
//   mem_*                 line-granular backing memory; mem_ack completes the current request
//   cm_*                  drive/read of the external tag+data array (1-cycle read latency, per-way write enables)
module cache_controller #(
    parameter int ADDRESS_WIDTH   = 32,
    parameter int SETS            = 1024,
    parameter int WAYS            = 2,     // only 2 is supported
    parameter int CACHE_LINE_SIZE = 32,
    parameter int TAG_WIDTH       = ADDRESS_WIDTH - ($clog2(SETS) + $clog2(CACHE_LINE_SIZE / 8))
) (
    input  logic                            clk,
    input  logic                            rst,
    // CPU side
    input  logic                            cpu_req,
    input  logic                            cpu_wen,
    input  logic [ADDRESS_WIDTH-1:0]        cpu_addr,
    input  logic [CACHE_LINE_SIZE-1:0]      cpu_wdata,
    output logic                            cpu_ready,
    output logic                            cpu_resp_valid,
    output logic [CACHE_LINE_SIZE-1:0]      cpu_rdata,
    // memory side
    output logic                            mem_req,
    output logic                            mem_wen,
    output logic [ADDRESS_WIDTH-1:0]        mem_addr,
    output logic [CACHE_LINE_SIZE-1:0]      mem_wdata,
    input  logic [CACHE_LINE_SIZE-1:0]      mem_rdata,
    input  logic                            mem_ack,
    // cache array side
    output logic                            cm_req,
    output logic [ADDRESS_WIDTH-1:0]        cm_address,
    output logic [CACHE_LINE_SIZE-1:0]      cm_data_in,
    output logic [TAG_WIDTH-1:0]            cm_tag_in,
    output logic [2*WAYS-1:0]               cm_valid_dirty_in,
    output logic [WAYS-1:0]                 cm_wen_data,
    output logic [WAYS-1:0]                 cm_wen_tag,
    input  logic [WAYS*CACHE_LINE_SIZE-1:0] cm_data_out,
    input  logic [WAYS*TAG_WIDTH-1:0]       cm_tag_out,
    input  logic [2*WAYS-1:0]               cm_valid_dirty_out
);

    localparam int OFFSET_W = $clog2(CACHE_LINE_SIZE / 8);
    localparam int SET_W    = $clog2(SETS);
    localparam int VD_W     = 2 * WAYS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WRITEBACK,
        S_REFILL,
        S_INSTALL
    } state_t;

    state_t state_q, state_d;

    // request and victim holding registers
    logic [ADDRESS_WIDTH-1:0]   addr_q;
    logic                       wen_q;
    logic [CACHE_LINE_SIZE-1:0] wdata_q;
    logic                       victim_way_q;
    logic [TAG_WIDTH-1:0]       victim_tag_q;
    logic [CACHE_LINE_SIZE-1:0] victim_data_q;
    logic [CACHE_LINE_SIZE-1:0] refill_q;
    // one bit per set: the way to evict next
    logic [SETS-1:0]            lru_q;

    logic [SET_W-1:0]           set_idx;
    logic [TAG_WIDTH-1:0]       req_tag;

    assign set_idx = addr_q[OFFSET_W +: SET_W];
    assign req_tag = addr_q[ADDRESS_WIDTH-1 -: TAG_WIDTH];

    // per-way views of the array read port
    logic [CACHE_LINE_SIZE-1:0] data0, data1;
    logic [TAG_WIDTH-1:0]       tag0, tag1;
    logic [1:0]                 vd0, vd1;

    assign data0 = cm_data_out[0 +: CACHE_LINE_SIZE];
    assign data1 = cm_data_out[CACHE_LINE_SIZE +: CACHE_LINE_SIZE];
    assign tag0  = cm_tag_out[0 +: TAG_WIDTH];
    assign tag1  = cm_tag_out[TAG_WIDTH +: TAG_WIDTH];
    assign vd0   = cm_valid_dirty_out[1:0];
    assign vd1   = cm_valid_dirty_out[3:2];

    logic hit0, hit1, hit, hit_way;
    logic victim_way, victim_dirty;

    assign hit0    = vd0[0] && (tag0 == req_tag);
    assign hit1    = vd1[0] && (tag1 == req_tag);
    assign hit     = hit0 || hit1;
    assign hit_way = !hit0;   // way 0 wins when both report a hit

    // fill an invalid way first (lowest index), otherwise evict the LRU way
    always_comb begin
        victim_way = lru_q[set_idx];
        if (!vd0[0]) begin
            victim_way = 1'b0;
        end else if (!vd1[0]) begin
            victim_way = 1'b1;
        end
    end

    assign victim_dirty = victim_way ? (vd1[0] && vd1[1]) : (vd0[0] && vd0[1]);

    // control strobes from the FSM
    logic                       accept;
    logic                       miss_latch;
    logic                       refill_latch;
    logic                       lru_upd;
    logic                       lru_way;
    logic                       wr_en;
    logic                       wr_way;
    logic [1:0]                 wr_vd;
    logic [CACHE_LINE_SIZE-1:0] wr_data;

    always_comb begin
        state_d           = state_q;
        cpu_ready         = 1'b0;
        cpu_resp_valid    = 1'b0;
        cpu_rdata         = '0;
        mem_req           = 1'b0;
        mem_wen           = 1'b0;
        mem_addr          = '0;
        mem_wdata         = '0;
        cm_req            = 1'b0;
        cm_address        = '0;
        cm_data_in        = '0;
        cm_tag_in         = '0;
        cm_valid_dirty_in = '0;
        cm_wen_data       = '0;
        cm_wen_tag        = '0;
        accept            = 1'b0;
        miss_latch        = 1'b0;
        refill_latch      = 1'b0;
        lru_upd           = 1'b0;
        lru_way           = 1'b0;
        wr_en             = 1'b0;
        wr_way            = 1'b0;
        wr_vd             = 2'b00;
        wr_data           = '0;

        // everything stays quiet while rst is held, including mid-operation
        if (!rst) begin
            cm_address = addr_q;
            case (state_q)
                S_IDLE: begin
                    cpu_ready  = 1'b1;
                    // start the array read now so tags/data are ready in LOOKUP
                    cm_req     = cpu_req;
                    cm_address = cpu_addr;
                    if (cpu_req) begin
                        accept  = 1'b1;
                        state_d = S_LOOKUP;
                    end
                end

                S_LOOKUP: begin
                    if (hit) begin
                        cpu_resp_valid = 1'b1;
                        lru_upd        = 1'b1;
                        lru_way        = hit_way;
                        if (wen_q) begin
                            wr_en   = 1'b1;
                            wr_way  = hit_way;
                            wr_vd   = 2'b11;
                            wr_data = wdata_q;
                        end else begin
                            cpu_rdata = hit_way ? data1 : data0;
                        end
                        state_d = S_IDLE;
                    end else begin
                        miss_latch = 1'b1;
                        if (victim_dirty) begin
                            state_d = S_WRITEBACK;
                        end else if (wen_q) begin
                            // full-line write: no refill needed
                            state_d = S_INSTALL;
                        end else begin
                            state_d = S_REFILL;
                        end
                    end
                end

                S_WRITEBACK: begin
                    mem_req   = 1'b1;
                    mem_wen   = 1'b1;
                    mem_addr  = {victim_tag_q, set_idx, {OFFSET_W{1'b0}}};
                    mem_wdata = victim_data_q;
                    if (mem_ack) begin
                        state_d = wen_q ? S_INSTALL : S_REFILL;
                    end
                end

                S_REFILL: begin
                    mem_req  = 1'b1;
                    mem_addr = {req_tag, set_idx, {OFFSET_W{1'b0}}};
                    if (mem_ack) begin
                        refill_latch = 1'b1;
                        state_d      = S_INSTALL;
                    end
                end

                S_INSTALL: begin
                    wr_en          = 1'b1;
                    wr_way         = victim_way_q;
                    wr_vd          = wen_q ? 2'b11 : 2'b01;
                    wr_data        = wen_q ? wdata_q : refill_q;
                    cpu_resp_valid = 1'b1;
                    cpu_rdata      = wen_q ? '0 : refill_q;
                    lru_upd        = 1'b1;
                    lru_way        = victim_way_q;
                    state_d        = S_IDLE;
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase

            if (wr_en) begin
                cm_req            = 1'b1;
                cm_data_in        = wr_data;
                cm_tag_in         = req_tag;
                cm_wen_data       = WAYS'(1) << wr_way;
                cm_wen_tag        = WAYS'(1) << wr_way;
                cm_valid_dirty_in = VD_W'(wr_vd) << {wr_way, 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            lru_q   <= '0;
        end else begin
            state_q <= state_d;
            if (lru_upd) begin
                lru_q[set_idx] <= ~lru_way;
            end
        end
    end

    // datapath holding registers only load under FSM control, so they need no reset
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= cpu_addr;
            wen_q   <= cpu_wen;
            wdata_q <= cpu_wdata;
        end
        if (miss_latch) begin
            victim_way_q  <= victim_way;
            victim_tag_q  <= victim_way ? tag1 : tag0;
            victim_data_q <= victim_way ? data1 : data0;
        end
        if (refill_latch) begin
            refill_q <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
`timescale 1ns/1ps
module tb_cache_controller;
    localparam int AW   = 32;
    localparam int SETS = 1024;
    localparam int WAYS = 2;
    localparam int LW   = 32;
    localparam int TW   = 20;

    logic            clk       = 1'b0;
    logic            rst       = 1'b1;
    logic            cpu_req   = 1'b0;
    logic            cpu_wen   = 1'b0;
    logic [AW-1:0]   cpu_addr  = '0;
    logic [LW-1:0]   cpu_wdata = '0;
    logic            cpu_ready;
    logic            cpu_resp_valid;
    logic [LW-1:0]   cpu_rdata;
    logic            mem_req;
    logic            mem_wen;
    logic [AW-1:0]   mem_addr;
    logic [LW-1:0]   mem_wdata;
    logic [LW-1:0]   mem_rdata = '0;
    logic            mem_ack   = 1'b0;
    logic            cm_req;
    logic [AW-1:0]   cm_address;
    logic [LW-1:0]   cm_data_in;
    logic [TW-1:0]   cm_tag_in;
    logic [2*WAYS-1:0] cm_valid_dirty_in;
    logic [WAYS-1:0] cm_wen_data;
    logic [WAYS-1:0] cm_wen_tag;
    logic [WAYS*LW-1:0] cm_data_out = '0;
    logic [WAYS*TW-1:0] cm_tag_out  = '0;
    logic [2*WAYS-1:0]  cm_valid_dirty_out = '0;

    always #5 clk = ~clk;

    cache_controller #(
        .ADDRESS_WIDTH(AW), .SETS(SETS), .WAYS(WAYS), .CACHE_LINE_SIZE(LW)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_resp_valid(cpu_resp_valid), .cpu_rdata(cpu_rdata),
        .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .cm_req(cm_req), .cm_address(cm_address), .cm_data_in(cm_data_in), .cm_tag_in(cm_tag_in),
        .cm_valid_dirty_in(cm_valid_dirty_in), .cm_wen_data(cm_wen_data), .cm_wen_tag(cm_wen_tag),
        .cm_data_out(cm_data_out), .cm_tag_out(cm_tag_out), .cm_valid_dirty_out(cm_valid_dirty_out)
    );

    // ---------------- cache array model (1-cycle read latency) ----------------
    logic [LW-1:0] a_dat [2][SETS];
    logic [TW-1:0] a_tag [2][SETS];
    logic [1:0]    a_vd  [2][SETS];
    logic          arr_clr = 1'b0;
    wire  [9:0]    cm_set = cm_address[11:2];

    always @(posedge clk) begin
        if (arr_clr) begin
            for (int s = 0; s < SETS; s++) begin
                a_vd[0][s] <= 2'b00;
                a_vd[1][s] <= 2'b00;
            end
        end else if (cm_req) begin
            cm_data_out        <= {a_dat[1][cm_set], a_dat[0][cm_set]};
            cm_tag_out         <= {a_tag[1][cm_set], a_tag[0][cm_set]};
            cm_valid_dirty_out <= {a_vd[1][cm_set], a_vd[0][cm_set]};
            for (int w = 0; w < 2; w++) begin
                if (cm_wen_data[w]) a_dat[w][cm_set] <= cm_data_in;
                if (cm_wen_tag[w]) begin
                    a_tag[w][cm_set] <= cm_tag_in;
                    a_vd[w][cm_set]  <= cm_valid_dirty_in[2*w +: 2];
                end
            end
        end
    end

    // ---------------- scoreboard state ----------------
    typedef struct {
        string       name;
        logic        is_rd;
        logic [31:0] rdata;
        int          acc;
        int          lat;
    } rsp_t;
    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mtx_t;

    rsp_t        rsp_q[$];
    mtx_t        mem_q[$];
    logic [31:0] mem_model [logic [31:0]];
    int          cyc      = 0;
    int          n_cmp    = 0;
    int          n_bad    = 0;
    int          n_pushed = 0;
    int          n_rsp    = 0;
    int          ack_lat  = 3;
    int          wcnt     = 0;
    rsp_t        mon_r;
    mtx_t        mon_m;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
        end
    endtask

    task automatic unexpected(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event seen, required none", nm);
    endtask

    // ---------------- monitor + memory responder ----------------
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (cpu_resp_valid) begin
                n_rsp++;
                if (rsp_q.size() == 0) begin
                    unexpected("unexpected_response");
                end else begin
                    mon_r = rsp_q.pop_front();
                    check({mon_r.name, "_latency"}, 32'(cyc - mon_r.acc), 32'(mon_r.lat));
                    if (mon_r.is_rd) check({mon_r.name, "_rdata"}, cpu_rdata, mon_r.rdata);
                end
            end
            mem_ack = 1'b0;
            if (mem_req) begin
                if (mem_q.size() == 0) begin
                    unexpected("unexpected_mem_req");
                    wcnt = 0;
                end else begin
                    mon_m = mem_q[0];
                    check("mem_addr", mem_addr, mon_m.addr);
                    check("mem_wen", 32'(mem_wen), 32'(mon_m.wen));
                    if (mon_m.wen) check("mem_wdata", mem_wdata, mon_m.wdata);
                    if (wcnt >= ack_lat - 1) begin
                        mem_ack = 1'b1;
                        if (mem_wen) mem_model[mem_addr] = mem_wdata;
                        else mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'h0;
                        void'(mem_q.pop_front());
                        wcnt = 0;
                    end else begin
                        wcnt++;
                    end
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic exp_mem(input logic wen, input logic [31:0] addr, input logic [31:0] wd);
        mtx_t m;
        m.wen = wen; m.addr = addr; m.wdata = wd;
        mem_q.push_back(m);
    endtask

    task automatic push_rsp(input string nm, input logic is_rd, input logic [31:0] rd, input int acc, input int lat);
        rsp_t r;
        r.name = nm; r.is_rd = is_rd; r.rdata = rd; r.acc = acc; r.lat = lat;
        rsp_q.push_back(r);
        n_pushed++;
    endtask

    task automatic issue(input string nm, input logic wen, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input int lat, input bit want_rsp);
        int t = 0;
        cpu_req = 1'b1; cpu_wen = wen; cpu_addr = addr; cpu_wdata = wd;
        while (!cpu_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!cpu_ready) unexpected({nm, "_accept_timeout"});
        if (want_rsp) push_rsp(nm, !wen, exp_rd, cyc, lat);
        @(negedge clk);
        cpu_req = 1'b0; cpu_wen = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    endtask

    task automatic wait_done(input string nm);
        int t = 0;
        while (n_rsp < n_pushed && t < 300) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        check({nm, "_rsp_count"}, 32'(n_rsp), 32'(n_pushed));
        check({nm, "_mem_left"}, 32'(mem_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; arr_clr = 1'b1;
        @(negedge clk);
        #1;
        check("rst_cpu_ready", 32'(cpu_ready), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_cm_req", 32'(cm_req), 32'd0);
        check("rst_resp_valid", 32'(cpu_resp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0; arr_clr = 1'b0;
        #1;
        check("post_rst_ready", 32'(cpu_ready), 32'd1);
    endtask

    // ---------------- directed vectors ----------------
    initial begin : stim
        int t;
        int acc1;
        int base;
        mem_model[32'h1004] = 32'hDEADBEEF;
        mem_model[32'h2004] = 32'h22222222;
        mem_model[32'h3004] = 32'h33333333;
        mem_model[32'h5008] = 32'h55555555;
        mem_model[32'h6008] = 32'h66666666;

        // read miss then hit
        do_reset();
        exp_mem(1'b0, 32'h1004, 32'h0);
        issue("rd_miss", 1'b0, 32'h1004, 32'h0, 32'hDEADBEEF, 5, 1'b1);
        wait_done("rd_miss");
        issue("rd_hit", 1'b0, 32'h1004, 32'h0, 32'hDEADBEEF, 1, 1'b1);
        wait_done("rd_hit");

        // write hit, then read back
        issue("wr_hit", 1'b1, 32'h1004, 32'h12345678, 32'h0, 1, 1'b1);
        wait_done("wr_hit");
        issue("rd_after_wr", 1'b0, 32'h1004, 32'h0, 32'h12345678, 1, 1'b1);
        wait_done("rd_after_wr");

        // LRU eviction: 0x1004 way0, 0x2004 way1, touch 0x1004, 0x3004 evicts way1
        do_reset();
        exp_mem(1'b0, 32'h1004, 32'h0);
        issue("lru_a", 1'b0, 32'h1004, 32'h0, 32'hDEADBEEF, 5, 1'b1);
        wait_done("lru_a");
        exp_mem(1'b0, 32'h2004, 32'h0);
        issue("lru_b", 1'b0, 32'h2004, 32'h0, 32'h22222222, 5, 1'b1);
        wait_done("lru_b");
        issue("lru_a_hit", 1'b0, 32'h1004, 32'h0, 32'hDEADBEEF, 1, 1'b1);
        wait_done("lru_a_hit");
        exp_mem(1'b0, 32'h3004, 32'h0);
        issue("lru_c", 1'b0, 32'h3004, 32'h0, 32'h33333333, 5, 1'b1);
        wait_done("lru_c");
        issue("lru_a_hit2", 1'b0, 32'h1004, 32'h0, 32'hDEADBEEF, 1, 1'b1);
        wait_done("lru_a_hit2");
        exp_mem(1'b0, 32'h2004, 32'h0);
        issue("lru_b_miss", 1'b0, 32'h2004, 32'h0, 32'h22222222, 5, 1'b1);
        wait_done("lru_b_miss");

        // dirty eviction: clean write misses install directly, then writeback + refill
        do_reset();
        issue("dirty_wa", 1'b1, 32'h1004, 32'h0000000A, 32'h0, 2, 1'b1);
        wait_done("dirty_wa");
        issue("dirty_wb", 1'b1, 32'h2004, 32'h0000000B, 32'h0, 2, 1'b1);
        wait_done("dirty_wb");
        exp_mem(1'b1, 32'h1004, 32'h0000000A);
        exp_mem(1'b0, 32'h3004, 32'h0);
        issue("dirty_evict", 1'b0, 32'h3004, 32'h0, 32'h33333333, 8, 1'b1);
        wait_done("dirty_evict");
        exp_mem(1'b1, 32'h2004, 32'h0000000B);
        exp_mem(1'b0, 32'h1004, 32'h0);
        issue("dirty_refetch", 1'b0, 32'h1004, 32'h0, 32'h0000000A, 8, 1'b1);
        wait_done("dirty_refetch");

        // reset while REFILL is waiting on memory
        do_reset();
        ack_lat = 50;
        exp_mem(1'b0, 32'h5008, 32'h0);
        issue("rst_refill", 1'b0, 32'h5008, 32'h0, 32'h0, 0, 1'b0);
        t = 0;
        while (!mem_req && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("rst_refill_mem_req_seen", 32'(mem_req), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_mem_req", 32'(mem_req), 32'd0);
        check("rst_mid_ready", 32'(cpu_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mid_mem_req_after", 32'(mem_req), 32'd0);
        check("rst_mid_ready_after", 32'(cpu_ready), 32'd1);
        mem_q.delete();
        ack_lat = 3;
        @(negedge clk);
        exp_mem(1'b0, 32'h5008, 32'h0);
        issue("rst_reread", 1'b0, 32'h5008, 32'h0, 32'h55555555, 5, 1'b1);
        wait_done("rst_reread");

        // request held high while busy: taken only on the first IDLE cycle
        base = n_rsp;
        exp_mem(1'b0, 32'h6008, 32'h0);
        cpu_req = 1'b1; cpu_wen = 1'b0; cpu_addr = 32'h6008; cpu_wdata = '0;
        t = 0;
        while (!cpu_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        acc1 = cyc;
        push_rsp("busy_x", 1'b1, 32'h66666666, cyc, 5);
        @(negedge clk);
        cpu_addr = 32'h5008;
        t = 0;
        while (!cpu_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("busy_accept_cycle", 32'(cyc - acc1), 32'd6);
        push_rsp("busy_y", 1'b1, 32'h55555555, cyc, 1);
        @(negedge clk);
        cpu_req = 1'b0; cpu_addr = '0;
        wait_done("busy");
        repeat (5) @(negedge clk);
        check("busy_rsp_total", 32'(n_rsp - base), 32'd2);
        check("final_rsp_queue_empty", 32'(rsp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

endmodule
